// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave terminating the bus into a word-organised SRAM with byte lanes,
// alignment/range checks and two-cycle ERROR. Define AHB_SLV_WAIT_EN for wait states.
module ahb_sram_slave #(
  parameter int AHB_ADDR_WIDTH  = 32,
  parameter int MEM_DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES     = 2
) (
  input  logic                      hclk,
  input  logic                      hresetn,
  input  logic                      hsel_i,
  input  logic [1:0]                htrans_i,
  input  logic [2:0]                hsize_i,
  input  logic [AHB_ADDR_WIDTH-1:0] haddr_i,
  input  logic                      hwrite_i,
  input  logic [2:0]                hburst_i,
  input  logic [31:0]               hwdata_i,
  input  logic                      hready_i,
  output logic                      hreadyout_o,
  output logic [31:0]               hrdata_o,
  output logic [1:0]                hresp_o
);
  localparam int AW    = AHB_ADDR_WIDTH;
  localparam int IDX_W = (MEM_DEPTH_WORDS > 1) ? $clog2(MEM_DEPTH_WORDS) : 1;
  localparam logic [AW-3:0] DEPTH_W = (AW-2)'(MEM_DEPTH_WORDS);
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  function automatic logic xfer_error(input logic [2:0] size, input logic [AW-1:0] addr);
    logic bad;
    case (size)
      3'b000:  bad = 1'b0;
      3'b001:  bad = addr[0];
      3'b010:  bad = |addr[1:0];
      default: bad = 1'b1;
    endcase
    return bad | (addr[AW-1:2] >= DEPTH_W);
  endfunction

  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
    logic [3:0] m;
    case (size)
      3'b000:  m = 4'b0001 << a;
      3'b001:  m = a[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  state_t            state_q, state_d, pipe_next, ok_state;
  logic              accept, take, addr_err, phase_ok;
  logic [IDX_W-1:0]  idx_p1;
  logic [3:0]        lanes_p1;
  logic              write_p1;
  logic [31:0]       mem [MEM_DEPTH_WORDS];
  logic              unused_ok;

  assign unused_ok = ^{hburst_i, htrans_i[0]};

  // Address phase: only sampled while the slave is not stalling the bus.
  assign accept    = hsel_i & hready_i & htrans_i[1];
  assign phase_ok  = (state_q == S_IDLE) || (state_q == S_DATA) || (state_q == S_ERR2);
  assign take      = accept & phase_ok;
  assign addr_err  = xfer_error(hsize_i, haddr_i);
  assign pipe_next = take ? (addr_err ? S_ERR1 : ok_state) : S_IDLE;

`ifdef AHB_SLV_WAIT_EN
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);
  logic [3:0] wait_cnt;

  assign ok_state = (WAIT_LD != 4'd0) ? S_WAIT : S_DATA;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn)
      wait_cnt <= 4'd0;
    else if (take && !addr_err)
      wait_cnt <= WAIT_LD;
    else if (state_q == S_WAIT && wait_cnt != 4'd0)
      wait_cnt <= wait_cnt - 4'd1;
  end
`else
  logic [3:0] unused_wait;
  assign unused_wait = 4'(WAIT_CYCLES);
  assign ok_state    = S_DATA;
`endif

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d     = S_IDLE;
    hreadyout_o = 1'b1;
    hresp_o     = RESP_OKAY;
    case (state_q)
      S_IDLE: state_d = pipe_next;
      S_WAIT: begin
        hreadyout_o = 1'b0;
`ifdef AHB_SLV_WAIT_EN
        state_d = (wait_cnt <= 4'd1) ? S_DATA : S_WAIT;
`else
        state_d = S_DATA;
`endif
      end
      S_DATA: state_d = pipe_next;
      S_ERR1: begin
        hreadyout_o = 1'b0;
        hresp_o     = RESP_ERROR;
        state_d     = S_ERR2;
      end
      S_ERR2: begin
        hresp_o = RESP_ERROR;
        state_d = pipe_next;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Address-phase -> data-phase pipeline boundary.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      idx_p1   <= '0;
      lanes_p1 <= 4'b0000;
      write_p1 <= 1'b0;
    end else if (take) begin
      idx_p1   <= haddr_i[IDX_W+1:2];
      lanes_p1 <= lane_mask(hsize_i, haddr_i[1:0]);
      write_p1 <= hwrite_i;
    end
  end

  // Write commits on the edge that closes the data phase; reset drops it.
  always_ff @(posedge hclk) begin
    if (state_q == S_DATA && write_p1) begin
      for (int b = 0; b < 4; b++)
        if (lanes_p1[b]) mem[idx_p1][8*b +: 8] <= hwdata_i[8*b +: 8];
    end
  end

  assign hrdata_o = (state_q == S_DATA && !write_p1) ? mem[idx_p1] : 32'h0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: directed vector table, reset corner sequences and
// random pipelined traffic checked against a byte-level memory model.
`timescale 1ns/1ps
module tb_ahb_sram_slave;
  localparam int AW    = 32;
  localparam int DEPTH = 1024;
  localparam int WAITC = 2;
`ifdef AHB_SLV_WAIT_EN
  localparam int EXP_WAIT = WAITC;
`else
  localparam int EXP_WAIT = 0;
`endif

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        hsel = 1'b0;
  logic [1:0]  htrans = 2'b00;
  logic [2:0]  hsize = 3'b010;
  logic [31:0] haddr = 32'h0;
  logic        hwrite = 1'b0;
  logic [2:0]  hburst = 3'b001;
  logic [31:0] hwdata = 32'h0;
  logic        hready;
  logic        hreadyout;
  logic [31:0] hrdata;
  logic [1:0]  hresp;

  assign hready = hreadyout;

  ahb_sram_slave #(.AHB_ADDR_WIDTH(AW), .MEM_DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .hclk(hclk), .hresetn(hresetn), .hsel_i(hsel), .htrans_i(htrans), .hsize_i(hsize),
    .haddr_i(haddr), .hwrite_i(hwrite), .hburst_i(hburst), .hwdata_i(hwdata),
    .hready_i(hready), .hreadyout_o(hreadyout), .hrdata_o(hrdata), .hresp_o(hresp)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } xfer_t;

  typedef struct {
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  xfer_t       xq[$];
  vec_t        tbl[$];
  logic [31:0] mm [DEPTH];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [34:0] act, input logic [34:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got rdy=%0b resp=%0b rdata=%h, want rdy=%0b resp=%0b rdata=%h",
               name, act[34], act[33:32], act[31:0], exp[34], exp[33:32], exp[31:0]);
    end
  endtask

  // Reference: byte-addressed view of the SRAM, legality from size/alignment/range.
  function automatic void model(input logic wr, input logic [2:0] size, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic err, output logic [31:0] rdata);
    int nbytes;
    int ln;
    logic [31:0] w;
    nbytes = 1 << size;
    err = (size > 3'd2) || ((addr % nbytes) != 0) || ((addr / 4) >= DEPTH);
    rdata = 32'h0;
    if (!err) begin
      w = mm[addr / 4];
      if (wr) begin
        for (int k = 0; k < nbytes; k++) begin
          ln = (addr + k) % 4;
          w[ln*8 +: 8] = wdata[ln*8 +: 8];
        end
        mm[addr / 4] = w;
      end else begin
        rdata = w;
      end
    end
  endfunction

  function automatic void push(input logic sel, input logic [1:0] trans, input logic wr,
                               input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
    xfer_t x;
    logic e;
    logic [31:0] rd;
    e = 1'b0;
    rd = 32'h0;
    if (sel && trans[1]) model(wr, size, addr, wdata, e, rd);
    x.sel = sel; x.trans = trans; x.wr = wr; x.size = size; x.addr = addr; x.wdata = wdata;
    x.exp_err = e; x.exp_rdata = rd;
    xq.push_back(x);
  endfunction

  function automatic logic [34:0] dphase_exp(input int di, input int dcyc);
    if (di < 0) return {1'b1, 2'b00, 32'h0};
    if (!(xq[di].sel && xq[di].trans[1])) return {1'b1, 2'b00, 32'h0};
    if (xq[di].exp_err) return (dcyc == 0) ? {1'b0, 2'b01, 32'h0} : {1'b1, 2'b01, 32'h0};
    if (dcyc < EXP_WAIT) return {1'b0, 2'b00, 32'h0};
    return {1'b1, 2'b00, (xq[di].wr ? 32'h0 : xq[di].exp_rdata)};
  endfunction

  // Pipelined master: address phase of ai overlaps data phase of di.
  task automatic run_queue(input string tag);
    int ai = 0;
    int di = -1;
    int dcyc = 0;
    int guard = 0;
    int limit;
    logic rdy;
    limit = xq.size() * (EXP_WAIT + 3) + 10;
    while ((ai < xq.size() || di >= 0) && guard < limit) begin
      if (ai < xq.size()) begin
        hsel = xq[ai].sel; htrans = xq[ai].trans; hwrite = xq[ai].wr;
        hsize = xq[ai].size; haddr = xq[ai].addr;
      end else begin
        hsel = 1'b0; htrans = 2'b00;
      end
      hwdata = (di >= 0) ? xq[di].wdata : $urandom;
      @(negedge hclk);
      check($sformatf("%s_x%0d_c%0d", tag, di, dcyc), {hreadyout, hresp, hrdata}, dphase_exp(di, dcyc));
      rdy = hreadyout;
      @(posedge hclk);
      #1;
      if (rdy) begin
        if (ai < xq.size()) begin di = ai; ai++; end
        else di = -1;
        dcyc = 0;
      end else begin
        dcyc++;
      end
      guard++;
    end
    if (guard >= limit) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: got stalled after %0d cycles, want completion", tag, guard);
    end
    hsel = 1'b0; htrans = 2'b00;
    xq.delete();
  endtask

  function automatic vec_t mkv(input logic [1:0] t, input logic wr, input logic [2:0] sz,
                               input logic [31:0] a, input logic [31:0] wd, input logic e, input logic [31:0] rd);
    vec_t v;
    v.trans = t; v.wr = wr; v.size = sz; v.addr = a; v.wdata = wd; v.exp_err = e; v.exp_rdata = rd;
    return v;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    xfer_t x;
    logic e;
    logic [31:0] rd;
    int r, p, q;
    logic [1:0] tr;
    logic [2:0] sz;
    logic [31:0] ad;

    tbl.push_back(mkv(2'b10, 1, 3'd2, 32'h10,  32'hDEADBEEF, 0, 32'h0));
    tbl.push_back(mkv(2'b10, 0, 3'd2, 32'h10,  32'h0,        0, 32'hDEADBEEF));
    tbl.push_back(mkv(2'b10, 1, 3'd2, 32'h10,  32'h11223344, 0, 32'h0));
    tbl.push_back(mkv(2'b10, 1, 3'd0, 32'h13,  32'hAA000000, 0, 32'h0));
    tbl.push_back(mkv(2'b10, 0, 3'd2, 32'h10,  32'h0,        0, 32'hAA223344));
    tbl.push_back(mkv(2'b10, 1, 3'd1, 32'h21,  32'h00FFFF00, 1, 32'h0));
    tbl.push_back(mkv(2'b10, 0, 3'd2, 32'h20,  32'h0,        0, 32'h0));
    tbl.push_back(mkv(2'b10, 0, 3'd2, 32'h1000, 32'h0,       1, 32'h0));
    tbl.push_back(mkv(2'b00, 0, 3'd2, 32'h10,  32'h0,        0, 32'h0));
    tbl.push_back(mkv(2'b10, 1, 3'd3, 32'h0,   32'h12345678, 1, 32'h0));
    tbl.push_back(mkv(2'b10, 1, 3'd2, 32'h2,   32'h12345678, 1, 32'h0));
    tbl.push_back(mkv(2'b10, 1, 3'd1, 32'h22,  32'hBEEF0000, 0, 32'h0));
    tbl.push_back(mkv(2'b10, 1, 3'd0, 32'h21,  32'h00005500, 0, 32'h0));
    tbl.push_back(mkv(2'b10, 0, 3'd2, 32'h20,  32'h0,        0, 32'hBEEF5500));
    tbl.push_back(mkv(2'b10, 1, 3'd2, 32'h40,  32'd1,        0, 32'h0));
    tbl.push_back(mkv(2'b11, 1, 3'd2, 32'h44,  32'd2,        0, 32'h0));
    tbl.push_back(mkv(2'b11, 1, 3'd2, 32'h48,  32'd3,        0, 32'h0));
    tbl.push_back(mkv(2'b11, 1, 3'd2, 32'h4C,  32'd4,        0, 32'h0));
    tbl.push_back(mkv(2'b10, 0, 3'd2, 32'h40,  32'h0,        0, 32'd1));
    tbl.push_back(mkv(2'b11, 0, 3'd2, 32'h44,  32'h0,        0, 32'd2));
    tbl.push_back(mkv(2'b11, 0, 3'd2, 32'h48,  32'h0,        0, 32'd3));
    tbl.push_back(mkv(2'b11, 0, 3'd2, 32'h4C,  32'h0,        0, 32'd4));
    tbl.push_back(mkv(2'b10, 1, 3'd2, 32'hFFC, 32'hCAFEF00D, 0, 32'h0));
    tbl.push_back(mkv(2'b10, 0, 3'd2, 32'hFFC, 32'h0,        0, 32'hCAFEF00D));
    tbl.push_back(mkv(2'b10, 1, 3'd0, 32'hFFF, 32'h77000000, 0, 32'h0));
    tbl.push_back(mkv(2'b10, 0, 3'd2, 32'hFFC, 32'h0,        0, 32'h77FEF00D));
    tbl.push_back(mkv(2'b10, 0, 3'd0, 32'h1000, 32'h0,       1, 32'h0));
    tbl.push_back(mkv(2'b10, 1, 3'd2, 32'h80,  32'h12345678, 0, 32'h0));
    tbl.push_back(mkv(2'b10, 0, 3'd1, 32'h82,  32'h0,        0, 32'h12345678));

    // Reset state, checked while reset is held.
    #2;
    check("reset_state", {hreadyout, hresp, hrdata}, {1'b1, 2'b00, 32'h0});
    repeat (2) @(posedge hclk);
    #1 hresetn = 1'b1;

    for (int w = 0; w < DEPTH; w++) push(1'b1, 2'b10, 1'b1, 3'd2, 32'(w * 4), 32'h0);
    run_queue("init");

    for (int i = 0; i < tbl.size(); i++) begin
      x.sel = 1'b1; x.trans = tbl[i].trans; x.wr = tbl[i].wr; x.size = tbl[i].size;
      x.addr = tbl[i].addr; x.wdata = tbl[i].wdata;
      x.exp_err = tbl[i].exp_err; x.exp_rdata = tbl[i].exp_rdata;
      if (tbl[i].trans[1]) model(tbl[i].wr, tbl[i].size, tbl[i].addr, tbl[i].wdata, e, rd);
      xq.push_back(x);
    end
    run_queue("tbl");

    // Reset asserted during the first ERROR cycle.
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; hsize = 3'd2; haddr = 32'h1000;
    @(negedge hclk);
    check("err_addr_phase", {hreadyout, hresp, hrdata}, {1'b1, 2'b00, 32'h0});
    @(posedge hclk);
    #1 hsel = 1'b0; htrans = 2'b00;
    @(negedge hclk);
    check("err1_before_rst", {hreadyout, hresp, hrdata}, {1'b0, 2'b01, 32'h0});
    hresetn = 1'b0;
    #1;
    check("rst_in_err1", {hreadyout, hresp, hrdata}, {1'b1, 2'b00, 32'h0});
    @(posedge hclk);
    #1 hresetn = 1'b1;

    // Reset asserted during a pending write; the location must keep its value.
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h80;
    @(negedge hclk);
    check("wr_addr_phase", {hreadyout, hresp, hrdata}, {1'b1, 2'b00, 32'h0});
    @(posedge hclk);
    #1 hsel = 1'b0; htrans = 2'b00; hwdata = 32'h5A5A5A5A;
    @(negedge hclk);
    check("wr_pending", {hreadyout, hresp, hrdata}, {(EXP_WAIT == 0), 2'b00, 32'h0});
    hresetn = 1'b0;
    #1;
    check("rst_in_wr", {hreadyout, hresp, hrdata}, {1'b1, 2'b00, 32'h0});
    @(posedge hclk);
    #1 hresetn = 1'b1;
    push(1'b1, 2'b10, 1'b0, 3'd2, 32'h80, 32'h0);
    run_queue("after_rst");

    // Random pipelined traffic, concentrated on a small window for address reuse.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      tr = (r < 8) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
      p = $urandom_range(0, 9);
      sz = (p < 3) ? 3'd0 : (p < 6) ? 3'd1 : (p < 9) ? 3'd2 : 3'($urandom_range(3, 7));
      q = $urandom_range(0, 19);
      ad = (q == 0) ? 32'($urandom_range(4 * DEPTH, 4 * DEPTH + 64)) :
           (q == 1) ? 32'(4 * DEPTH - 4 + $urandom_range(0, 3)) : 32'($urandom_range(0, 127));
      push((r >= 3), tr, 1'($urandom_range(0, 1)), sz, ad, $urandom);
    end
    run_queue("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
